// File: rtl/adsr_step_seq.sv
// Step sequencer feeding the adsr envelope: plays a STEPS-entry pattern, emitting trig/note per step.
// Optional odd-step swing delay is compiled in with SEQ_SWING_EN.
module adsr_step_seq #(
  parameter int STEPS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic [15:0]       tempo_div,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_data,
  input  logic [5:0]        swing,
  output logic              trig,
  output logic [7:0]        note,
  output logic [ADDR_W-1:0] step_idx,
  output logic              step_pulse
);

`ifdef SEQ_SWING_EN
  typedef enum logic [1:0] {IDLE, DELAY, GATE, REST} state_t;
`else
  typedef enum logic [1:0] {IDLE, GATE, REST} state_t;
  logic unused_swing;
  assign unused_swing = ^swing;
`endif

  state_t            state, state_d;
  logic [15:0]       pat [STEPS];
  logic [15:0]       div, div_d;
  logic [6:0]        sub, sub_d, sub_nxt;
  logic [6:0]        cur_gate, cur_gate_d;
  logic              trig_d, pulse_d;
  logic [7:0]        note_d;
  logic [ADDR_W-1:0] idx_d, nxt_idx;
  logic [15:0]       entry;
  logic              tick, boundary, start, gate_on;

  assign tick     = (div >= tempo_div);
  assign sub_nxt  = sub + 7'd1;
  assign boundary = (state != IDLE) && tick && (sub == 7'd127);
  assign start    = (state == IDLE) && run;
  assign nxt_idx  = (state == IDLE || step_idx == ADDR_W'(STEPS - 1)) ? '0 : step_idx + 1'b1;
  // Read happens before any same-edge write lands, so a colliding write plays next lap.
  assign entry    = pat[nxt_idx];
  assign gate_on  = entry[15] && (entry[14:8] != 7'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STEPS; i++) pat[i] <= '0;
    end else if (cfg_we && ({1'b0, cfg_addr} < (ADDR_W+1)'(STEPS))) begin
      pat[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      trig       <= 1'b0;
      note       <= 8'd0;
      step_idx   <= '0;
      step_pulse <= 1'b0;
      div        <= 16'd0;
      sub        <= 7'd0;
      cur_gate   <= 7'd0;
    end else begin
      state      <= state_d;
      trig       <= trig_d;
      note       <= note_d;
      step_idx   <= idx_d;
      step_pulse <= pulse_d;
      div        <= div_d;
      sub        <= sub_d;
      cur_gate   <= cur_gate_d;
    end
  end

  always_comb begin
    state_d    = state;
    trig_d     = trig;
    note_d     = note;
    idx_d      = step_idx;
    pulse_d    = 1'b0;
    div_d      = div;
    sub_d      = sub;
    cur_gate_d = cur_gate;
    if (!run) begin
      state_d = IDLE;
      trig_d  = 1'b0;
      idx_d   = '0;
      div_d   = 16'd0;
      sub_d   = 7'd0;
    end else if (start || boundary) begin
      pulse_d    = 1'b1;
      idx_d      = nxt_idx;
      note_d     = entry[7:0];
      cur_gate_d = entry[14:8];
      div_d      = 16'd0;
      sub_d      = 7'd0;
      state_d    = gate_on ? GATE : REST;
`ifdef SEQ_SWING_EN
      if (gate_on && nxt_idx[0] && (swing != 6'd0)) state_d = DELAY;
`endif
      trig_d     = (state_d == GATE);
    end else if (state != IDLE) begin
      if (tick) begin
        div_d = 16'd0;
        sub_d = sub_nxt;
      end else begin
        div_d = div + 16'd1;
      end
      case (state)
        GATE: begin
          if (tick && sub_nxt == cur_gate) begin
            state_d = REST;
            trig_d  = 1'b0;
          end
        end
`ifdef SEQ_SWING_EN
        DELAY: begin
          // A swing at or past the gate end swallows the whole trig for this step.
          if (tick && sub_nxt == {1'b0, swing}) begin
            if ({1'b0, swing} < cur_gate) begin
              state_d = GATE;
              trig_d  = 1'b1;
            end else begin
              state_d = REST;
            end
          end
        end
`endif
        default: trig_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_step_seq.sv
// Directed bench for adsr_step_seq: reset, gate timing, wrap, disabled step, stop/restart,
// write/boundary collision, swing (expectation follows SEQ_SWING_EN), reset mid-step.
module tb_adsr_step_seq;
  logic        clk = 1'b0;
  logic        rstn;
  logic        run;
  logic [15:0] tempo_div;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [5:0]  swing;
  logic        trig;
  logic [7:0]  note;
  logic [2:0]  step_idx;
  logic        step_pulse;

  int passed = 0;
  int total  = 0;

`ifdef SEQ_SWING_EN
  localparam bit SWING = 1'b1;
`else
  localparam bit SWING = 1'b0;
`endif

  adsr_step_seq #(.STEPS(8), .ADDR_W(3)) dut (
    .clk(clk), .rstn(rstn), .run(run), .tempo_div(tempo_div),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .swing(swing),
    .trig(trig), .note(note), .step_idx(step_idx), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic stop_seq();
    run = 1'b0;
    tick(1);
  endtask

  initial begin
    rstn = 1'b0; run = 1'b0; tempo_div = 16'd0; cfg_we = 1'b0;
    cfg_addr = 3'd0; cfg_data = 16'd0; swing = 6'd0;
    tick(3);
    chk("rst_trig", 16'(trig), 16'd0);
    chk("rst_note", 16'(note), 16'd0);
    chk("rst_idx", 16'(step_idx), 16'd0);
    chk("rst_pulse", 16'(step_pulse), 16'd0);
    rstn = 1'b1;
    tick(1);

    // Basic timing: entry0 = {1,64,60}, tempo_div 0.
    wr(3'd0, 16'hC03C);
    run = 1'b1;                 // cycle 0
    tick(1);                    // cycle 1
    chk("a_pulse1", 16'(step_pulse), 16'd1);
    chk("a_trig1", 16'(trig), 16'd1);
    chk("a_note1", 16'(note), 16'd60);
    chk("a_idx1", 16'(step_idx), 16'd0);
    tick(1);
    chk("a_pulse2", 16'(step_pulse), 16'd0);
    tick(62);                   // cycle 64
    chk("a_trig64", 16'(trig), 16'd1);
    tick(1);                    // cycle 65
    chk("a_trig65", 16'(trig), 16'd0);
    tick(63);                   // cycle 128
    chk("a_pulse128", 16'(step_pulse), 16'd0);
    tick(1);                    // cycle 129, entry1 still cleared
    chk("a_pulse129", 16'(step_pulse), 16'd1);
    chk("a_idx129", 16'(step_idx), 16'd1);
    chk("a_trig129", 16'(trig), 16'd0);
    chk("a_note129", 16'(note), 16'd0);
    stop_seq();
    chk("a_stop_idx", 16'(step_idx), 16'd0);

    // Full lap, tempo_div 1, gate 10, step 3 disabled.
    tempo_div = 16'd1;
    for (int i = 0; i < 8; i++)
      wr(3'(i), 16'((i == 3 ? 0 : 16'h8000) | (10 << 8) | (40 + i)));
    run = 1'b1;
    tick(1);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b_pulse%0d", k), 16'(step_pulse), 16'd1);
      chk($sformatf("b_idx%0d", k), 16'(step_idx), 16'(k % 8));
      chk($sformatf("b_note%0d", k), 16'(note), 16'(40 + k % 8));
      chk($sformatf("b_trig_on%0d", k), 16'(trig), (k % 8 == 3) ? 16'd0 : 16'd1);
      tick(19);
      chk($sformatf("b_trig_end%0d", k), 16'(trig), (k % 8 == 3) ? 16'd0 : 16'd1);
      tick(1);
      chk($sformatf("b_trig_off%0d", k), 16'(trig), 16'd0);
      chk($sformatf("b_pulse_off%0d", k), 16'(step_pulse), 16'd0);
      tick(236);
    end

    // Stop in mid-GATE of step 2, then restart.
    stop_seq();
    run = 1'b1;
    tick(1);
    tick(512);
    chk("c_idx2", 16'(step_idx), 16'd2);
    chk("c_pulse2", 16'(step_pulse), 16'd1);
    tick(5);
    chk("c_trig_gate", 16'(trig), 16'd1);
    run = 1'b0;
    tick(1);
    chk("c_trig_stop", 16'(trig), 16'd0);
    chk("c_idx_stop", 16'(step_idx), 16'd0);
    chk("c_note_hold", 16'(note), 16'd42);
    run = 1'b1;
    tick(1);
    chk("c_restart_pulse", 16'(step_pulse), 16'd1);
    chk("c_restart_idx", 16'(step_idx), 16'd0);
    chk("c_restart_note", 16'(note), 16'd40);
    chk("c_restart_trig", 16'(trig), 16'd1);

    // Write to entry1 on the edge that starts step 1.
    stop_seq();
    tempo_div = 16'd0;
    wr(3'd0, 16'hC03C);
    wr(3'd1, 16'h9430);         // {1,20,48}
    run = 1'b1;                 // cycle 0
    tick(128);                  // cycle 128
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'h8548;  // {1,5,72}
    tick(1);                    // cycle 129
    cfg_we = 1'b0;
    chk("d_pulse", 16'(step_pulse), 16'd1);
    chk("d_idx", 16'(step_idx), 16'd1);
    chk("d_note_old", 16'(note), 16'd48);
    chk("d_trig_on", 16'(trig), 16'd1);
    tick(19);
    chk("d_trig148", 16'(trig), 16'd1);
    tick(1);
    chk("d_trig149", 16'(trig), 16'd0);
    tick(1004);                 // cycle 1153, next lap of step 1
    chk("d_lap_pulse", 16'(step_pulse), 16'd1);
    chk("d_lap_idx", 16'(step_idx), 16'd1);
    chk("d_note_new", 16'(note), 16'd72);
    tick(4);
    chk("d_trig1157", 16'(trig), 16'd1);
    tick(1);
    chk("d_trig1158", 16'(trig), 16'd0);

    // Swing 8 with gate 20 on steps 0 and 1.
    stop_seq();
    swing = 6'd8;
    wr(3'd0, 16'h9410);
    wr(3'd1, 16'h9411);
    run = 1'b1;
    tick(1);                    // cycle 1
    chk("e_even_trig", 16'(trig), 16'd1);
    tick(128);                  // cycle 129
    chk("e_odd_pulse", 16'(step_pulse), 16'd1);
    chk("e_odd_note", 16'(note), 16'd17);
    chk("e_odd_trig0", 16'(trig), SWING ? 16'd0 : 16'd1);
    tick(7);                    // cycle 136
    chk("e_odd_trig7", 16'(trig), SWING ? 16'd0 : 16'd1);
    tick(1);                    // cycle 137
    chk("e_odd_trig8", 16'(trig), 16'd1);
    tick(11);                   // cycle 148
    chk("e_odd_trig19", 16'(trig), 16'd1);
    tick(1);                    // cycle 149
    chk("e_odd_trig20", 16'(trig), 16'd0);

    // Reset while step 2 is gating.
    tick(108);                  // cycle 257
    chk("f_pulse", 16'(step_pulse), 16'd1);
    chk("f_trig", 16'(trig), 16'd1);
    rstn = 1'b0;
    tick(1);
    chk("f_rst_trig", 16'(trig), 16'd0);
    chk("f_rst_idx", 16'(step_idx), 16'd0);
    chk("f_rst_note", 16'(note), 16'd0);
    rstn = 1'b1;
    run = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
